// File: rtl/warp_issue_arbiter.sv
// Per-warp lifecycle tracker with round-robin issue arbitration for a shared
// fetch/decode/ALU pipeline; memory-blocked warps are parked until mem_done.
module warp_issue_arbiter #(
    parameter int NUM_WARPS = 4,
    localparam int WARP_BITS = $clog2(NUM_WARPS)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_WARPS-1:0]   start,
    input  logic                   issue_ready,
    output logic                   issue_valid,
    output logic [WARP_BITS-1:0]   issue_warp,
    input  logic                   retire_valid,
    input  logic [WARP_BITS-1:0]   retire_warp,
    input  logic [1:0]             retire_kind,
    input  logic [NUM_WARPS-1:0]   mem_done,
    output logic [3*NUM_WARPS-1:0] warp_state,
    output logic [NUM_WARPS-1:0]   done,
    output logic                   all_done,
    output logic                   protocol_err
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_READY    = 3'd1,
        ST_ISSUED   = 3'd2,
        ST_WAIT_MEM = 3'd3,
        ST_DONE     = 3'd4
    } warp_st_e;

    warp_st_e               r_state [NUM_WARPS];
    warp_st_e               w_next  [NUM_WARPS];
    logic [WARP_BITS-1:0]   r_last_grant;
    logic                   r_protocol_err;

    logic [NUM_WARPS-1:0]   w_ready;
    logic [NUM_WARPS-1:0]   w_retire_hit;
    logic                   w_issue_valid;
    logic [WARP_BITS-1:0]   w_issue_warp;
    logic [WARP_BITS-1:0]   w_scan_idx;
    logic                   w_accept;
    logic                   w_retire_ok;
    logic                   w_mem_err;
    logic                   w_err_evt;

    // NOTE: the state array is small control state, so every entry is reset;
    // sequential blocks use <= so all warps update from the same old values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int w = 0; w < NUM_WARPS; w++) r_state[w] <= ST_IDLE;
            r_last_grant   <= WARP_BITS'(NUM_WARPS - 1);
            r_protocol_err <= 1'b0;
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) r_state[w] <= w_next[w];
            if (w_accept) r_last_grant <= w_issue_warp;
            r_protocol_err <= r_protocol_err | w_err_evt;
        end
    end

    // NOTE: every variable in a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        w_issue_valid = 1'b0;
        w_issue_warp  = r_last_grant;
        w_scan_idx    = r_last_grant;
        for (int i = 1; i <= NUM_WARPS; i++) begin
            w_scan_idx = WARP_BITS'((int'(r_last_grant) + i) % NUM_WARPS);
            if (!w_issue_valid && w_ready[w_scan_idx]) begin
                w_issue_valid = 1'b1;
                w_issue_warp  = w_scan_idx;
            end
        end
    end

    assign w_accept = w_issue_valid && issue_ready;

    always_comb begin
        w_retire_ok = 1'b0;
        w_mem_err   = 1'b0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            w_retire_hit[w] = retire_valid && (retire_warp == WARP_BITS'(w));
            w_next[w]       = r_state[w];
            case (r_state[w])
                ST_IDLE, ST_DONE: begin
                    if (start[w])    w_next[w] = ST_READY;
                    if (mem_done[w]) w_mem_err = 1'b1;
                end
                ST_READY: begin
                    if (w_accept && (w_issue_warp == WARP_BITS'(w))) w_next[w] = ST_ISSUED;
                    if (mem_done[w]) w_mem_err = 1'b1;
                end
                ST_ISSUED: begin
                    if (w_retire_hit[w]) begin
                        w_retire_ok = 1'b1;
                        case (retire_kind)
                            2'd1:    w_next[w] = mem_done[w] ? ST_READY : ST_WAIT_MEM;
                            2'd2:    w_next[w] = ST_DONE;
                            default: w_next[w] = ST_READY;
                        endcase
                    end
                    // mem_done is only legal here as the same-cycle fast path of a memory retire
                    if (mem_done[w] && !(w_retire_hit[w] && (retire_kind == 2'd1))) w_mem_err = 1'b1;
                end
                ST_WAIT_MEM: begin
                    if (mem_done[w]) w_next[w] = ST_READY;
                end
                default: w_next[w] = ST_IDLE;
            endcase
        end
        w_err_evt = (retire_valid && !w_retire_ok) || w_mem_err;
    end

    always_comb begin
        warp_state = '0;
        done       = '0;
        w_ready    = '0;
        all_done   = 1'b1;
        for (int w = 0; w < NUM_WARPS; w++) begin
            warp_state[3*w +: 3] = r_state[w];
            done[w]              = (r_state[w] == ST_DONE);
            w_ready[w]           = (r_state[w] == ST_READY);
            if ((r_state[w] == ST_READY) || (r_state[w] == ST_ISSUED) || (r_state[w] == ST_WAIT_MEM))
                all_done = 1'b0;
        end
        if (done == '0) all_done = 1'b0;
    end

    assign issue_valid  = w_issue_valid;
    assign issue_warp   = w_issue_warp;
    assign protocol_err = r_protocol_err;

endmodule

// File: tb/tb_warp_issue_arbiter.sv
// Scoreboard bench for warp_issue_arbiter: expected grants are queued as stimulus
// is planned and compared whenever the DUT makes an accepted issue.
module tb_warp_issue_arbiter;

    localparam int NW = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [NW-1:0] start = '0;
    logic          issue_ready = 1'b0;
    logic          issue_valid;
    logic [1:0]    issue_warp;
    logic          retire_valid = 1'b0;
    logic [1:0]    retire_warp = '0;
    logic [1:0]    retire_kind = '0;
    logic [NW-1:0] mem_done = '0;
    logic [3*NW-1:0] warp_state;
    logic [NW-1:0] done;
    logic          all_done;
    logic          protocol_err;

    int n_cmp = 0;
    int n_err = 0;
    int exp_q[$];
    int last_exp = 0;

    always #5 clk = ~clk;

    warp_issue_arbiter #(.NUM_WARPS(NW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .issue_ready  (issue_ready),
        .issue_valid  (issue_valid),
        .issue_warp   (issue_warp),
        .retire_valid (retire_valid),
        .retire_warp  (retire_warp),
        .retire_kind  (retire_kind),
        .mem_done     (mem_done),
        .warp_state   (warp_state),
        .done         (done),
        .all_done     (all_done),
        .protocol_err (protocol_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive at posedge+1, sample mid-cycle, clear pulses after the edge.
    task automatic cyc(input logic [NW-1:0] st, input logic rdy, input logic rv,
                       input logic [1:0] rw, input logic [1:0] rk, input logic [NW-1:0] md);
        start        = st;
        issue_ready  = rdy;
        retire_valid = rv;
        retire_warp  = rw;
        retire_kind  = rk;
        mem_done     = md;
        #2;
        if (issue_valid && issue_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_issue", 32'(issue_warp), NW);
            end else begin
                last_exp = exp_q.pop_front();
                check("issue_warp", 32'(issue_warp), 32'(last_exp));
            end
        end
        @(posedge clk);
        #1;
        start        = '0;
        issue_ready  = 1'b0;
        retire_valid = 1'b0;
        mem_done     = '0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        exp_q.delete();
        start = '0; issue_ready = 1'b0; retire_valid = 1'b0; mem_done = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    function automatic int wst(input int w);
        return int'(warp_state[3*w +: 3]);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset values
        do_reset();
        check("rst_issue_valid", 32'(issue_valid), 0);
        check("rst_issue_warp", 32'(issue_warp), NW - 1);
        check("rst_warp_state", 32'(warp_state), 0);
        check("rst_done", 32'(done), 0);
        check("rst_all_done", 32'(all_done), 0);
        check("rst_protocol_err", 32'(protocol_err), 0);

        // Basic launch and round-robin, each issue retired (kind 0) the next cycle
        cyc(4'b1111, 1'b0, 1'b0, 2'd0, 2'd0, 4'b0000);
        check("launch_ready", 32'(warp_state), 32'h249);
        for (int k = 0; k < 8; k++) exp_q.push_back(k % NW);
        cyc(4'b0000, 1'b1, 1'b0, 2'd0, 2'd0, 4'b0000);
        for (int k = 1; k < 8; k++) cyc(4'b0000, 1'b1, 1'b1, 2'(last_exp), 2'd0, 4'b0000);
        cyc(4'b0000, 1'b0, 1'b1, 2'(last_exp), 2'd0, 4'b0000);
        check("rr_drain", exp_q.size(), 0);
        check("rr_no_err", 32'(protocol_err), 0);
        check("rr_all_ready", 32'(warp_state), 32'h249);

        // RET every warp -> done mask, all_done on the last
        for (int k = 0; k < NW; k++) exp_q.push_back(k);
        cyc(4'b0000, 1'b1, 1'b0, 2'd0, 2'd0, 4'b0000);
        cyc(4'b0000, 1'b1, 1'b1, 2'(last_exp), 2'd2, 4'b0000);
        check("ret_done_w0", 32'(done), 32'b0001);
        cyc(4'b0000, 1'b1, 1'b1, 2'(last_exp), 2'd2, 4'b0000);
        cyc(4'b0000, 1'b1, 1'b1, 2'(last_exp), 2'd2, 4'b0000);
        check("ret_not_all_done", 32'(all_done), 0);
        cyc(4'b0000, 1'b0, 1'b1, 2'(last_exp), 2'd2, 4'b0000);
        check("ret_done_mask", 32'(done), 32'b1111);
        check("ret_all_done", 32'(all_done), 1);
        check("ret_state", 32'(warp_state), 32'h924);
        check("ret_drain", exp_q.size(), 0);
        check("ret_no_err", 32'(protocol_err), 0);

        // Memory parking of warp 0 while warp 1 keeps issuing
        do_reset();
        cyc(4'b0011, 1'b0, 1'b0, 2'd0, 2'd0, 4'b0000);
        exp_q.push_back(0);
        cyc(4'b0000, 1'b1, 1'b0, 2'd0, 2'd0, 4'b0000);
        exp_q.push_back(1);
        cyc(4'b0000, 1'b1, 1'b1, 2'd0, 2'd1, 4'b0000);
        check("park_w0_wait", wst(0), 3);
        cyc(4'b0000, 1'b1, 1'b1, 2'd1, 2'd0, 4'b0000);
        check("park_offer_valid", 32'(issue_valid), 1);
        check("park_offer_w1", 32'(issue_warp), 1);
        exp_q.push_back(1);
        cyc(4'b0000, 1'b1, 1'b0, 2'd0, 2'd0, 4'b0000);
        cyc(4'b0000, 1'b1, 1'b1, 2'd1, 2'd0, 4'b0000);
        exp_q.push_back(1);
        cyc(4'b0000, 1'b1, 1'b0, 2'd0, 2'd0, 4'b0001);
        check("park_w0_back", wst(0), 1);
        exp_q.push_back(0);
        cyc(4'b0000, 1'b1, 1'b1, 2'd1, 2'd0, 4'b0000);
        check("park_drain", exp_q.size(), 0);
        check("park_no_err", 32'(protocol_err), 0);

        // Fast path (kind 1 + mem_done same cycle) and start racing a RET
        do_reset();
        cyc(4'b0100, 1'b0, 1'b0, 2'd0, 2'd0, 4'b0000);
        exp_q.push_back(2);
        cyc(4'b0000, 1'b1, 1'b0, 2'd0, 2'd0, 4'b0000);
        cyc(4'b0000, 1'b0, 1'b1, 2'd2, 2'd1, 4'b0100);
        check("fast_w2_ready", wst(2), 1);
        check("fast_no_err", 32'(protocol_err), 0);
        check("fast_offer", 32'(issue_warp), 2);
        exp_q.push_back(2);
        cyc(4'b0000, 1'b1, 1'b0, 2'd0, 2'd0, 4'b0000);
        cyc(4'b0100, 1'b0, 1'b1, 2'd2, 2'd2, 4'b0000);
        check("race_w2_done", wst(2), 4);
        check("race_done_mask", 32'(done), 32'b0100);
        check("race_all_done", 32'(all_done), 1);
        check("race_no_err", 32'(protocol_err), 0);
        check("race_drain", exp_q.size(), 0);

        // Backpressure: offer stays on warp 1, then 1 and 3 issue in order
        do_reset();
        cyc(4'b1010, 1'b0, 1'b0, 2'd0, 2'd0, 4'b0000);
        for (int k = 0; k < 5; k++) begin
            check("bp_valid", 32'(issue_valid), 1);
            check("bp_warp", 32'(issue_warp), 1);
            cyc(4'b0000, 1'b0, 1'b0, 2'd0, 2'd0, 4'b0000);
        end
        exp_q.push_back(1);
        exp_q.push_back(3);
        cyc(4'b0000, 1'b1, 1'b0, 2'd0, 2'd0, 4'b0000);
        cyc(4'b0000, 1'b1, 1'b0, 2'd0, 2'd0, 4'b0000);
        check("bp_drain", exp_q.size(), 0);
        check("bp_state", 32'(warp_state), 32'h410);

        // Protocol errors are sticky and have no state effect
        do_reset();
        cyc(4'b0001, 1'b0, 1'b0, 2'd0, 2'd0, 4'b0000);
        cyc(4'b0000, 1'b0, 1'b1, 2'd2, 2'd0, 4'b0000);
        check("err_retire_idle", 32'(protocol_err), 1);
        check("err_w2_idle", wst(2), 0);
        cyc(4'b0000, 1'b0, 1'b0, 2'd0, 2'd0, 4'b0001);
        check("err_memdone_nochange", 32'(warp_state), 32'h001);
        repeat (3) cyc(4'b0000, 1'b0, 1'b0, 2'd0, 2'd0, 4'b0000);
        check("err_sticky", 32'(protocol_err), 1);
        do_reset();
        check("err_cleared", 32'(protocol_err), 0);

        // Asynchronous reset mid-run, then stale retire and a fresh launch
        cyc(4'b1111, 1'b0, 1'b0, 2'd0, 2'd0, 4'b0000);
        exp_q.push_back(0);
        cyc(4'b0000, 1'b1, 1'b0, 2'd0, 2'd0, 4'b0000);
        exp_q.push_back(1);
        cyc(4'b0000, 1'b1, 1'b1, 2'd0, 2'd1, 4'b0000);
        check("mid_drain", exp_q.size(), 0);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_issue_valid", 32'(issue_valid), 0);
        check("async_issue_warp", 32'(issue_warp), NW - 1);
        check("async_state", 32'(warp_state), 0);
        check("async_done", 32'(done), 0);
        check("async_all_done", 32'(all_done), 0);
        check("async_err", 32'(protocol_err), 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc(4'b0000, 1'b0, 1'b1, 2'd1, 2'd0, 4'b0000);
        check("stale_retire_err", 32'(protocol_err), 1);
        cyc(4'b1000, 1'b0, 1'b0, 2'd0, 2'd0, 4'b0000);
        exp_q.push_back(3);
        cyc(4'b0000, 1'b1, 1'b0, 2'd0, 2'd0, 4'b0000);
        check("restart_drain", exp_q.size(), 0);
        check("restart_w3_issued", wst(3), 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/warp_issue_arbiter.md
# warp_issue_arbiter

N-warp issue arbiter that time-multiplexes one shared fetch/decode/ALU pipeline among `NUM_WARPS` independent warps. It generalises the fixed two-warp select into a parametrised per-warp lifecycle tracker with round-robin grant. Warps that block on memory are parked, and their issue slots are reused by other warps. It sits between the per-warp launch/done interface of the core and the shared pipeline's issue and retire ports.

## Interface
- `NUM_WARPS`, 4: number of warps, ≥2; `WARP_BITS = $clog2(NUM_WARPS)` is a localparam.
- `clk` in 1: single clock, all state updates on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in NUM_WARPS: per-warp launch pulse.
- `issue_ready` in 1: the pipeline accepts the offered warp this cycle.
- `issue_valid` out 1: some warp is offered for issue.
- `issue_warp` out WARP_BITS: index of the offered warp.
- `retire_valid` in 1: the pipeline finished an instruction.
- `retire_warp` in WARP_BITS: warp of the retiring instruction.
- `retire_kind` in 2: 0 = normal, 1 = memory pending, 2 = RET, 3 = reserved (treated as 0).
- `mem_done` in NUM_WARPS: per-warp pulse, outstanding memory completed.
- `warp_state` out 3*NUM_WARPS: packed per-warp state, warp w at bits [3w+2:3w].
- `done` out NUM_WARPS: warp w is in DONE.
- `all_done` out 1: no warp is active, and at least one warp is DONE.
- `protocol_err` out 1: sticky, set on an illegal retire or mem_done.

## Operation
- Per-warp states and encodings: IDLE=0, READY=1, ISSUED=2, WAIT_MEM=3, DONE=4.
- IDLE or DONE + `start[w]` → READY. A start in any other state is ignored and is not an error.
- READY → ISSUED on the cycle warp w is offered while `issue_ready`=1.
- ISSUED + retire (w):
  - kind 0 or 3 → READY.
  - kind 1 → WAIT_MEM.
  - kind 2 → DONE.
- WAIT_MEM + `mem_done[w]` → READY.
- At most one instruction in flight per warp; ISSUED warps are never re-offered.
- Round-robin arbitration:
  - Register `last_grant` (WARP_BITS) resets to NUM_WARPS-1.
  - `issue_warp` is the first READY warp scanning last_grant+1, last_grant+2, … modulo NUM_WARPS.
  - `last_grant` updates to `issue_warp` only on an accepted issue.
  - `issue_valid` = at least one READY warp.
  - When `issue_valid`=0, `issue_warp` holds `last_grant`.
- Starvation bound: a READY warp is granted within NUM_WARPS accepted issues.
- `issue_valid` and `issue_warp` are combinational from registered state and `last_grant`. They have no combinational dependence on `issue_ready`, `retire_*` or `mem_done`.
- `done`, `warp_state` and `all_done` are combinational from the state registers.
- `protocol_err` is set by:
  - a retire whose warp is not ISSUED;
  - `mem_done[w]` while w is not WAIT_MEM (except the fast path below).
  - The offending event has no state effect, and the flag clears only on reset.

## Timing
- Reset (async assert, sync-to-clk deassert by the integrator):
  - all warps IDLE, `last_grant`=NUM_WARPS-1;
  - `issue_valid`=0, `issue_warp`=NUM_WARPS-1;
  - `done`=0, `all_done`=0, `protocol_err`=0, `warp_state`=0.
- Reset mid-operation discards all in-flight state. Retires arriving after deassert for pre-reset issues raise `protocol_err`.
- Latency:
  - start → `issue_valid` 1 cycle later (READY visible on the next cycle).
  - retire kind 0 → the same warp is eligible the next cycle.
  - retire kind 2 → `done[w]` high the next cycle.
- Same-cycle events:
  - Retire (kind 1) and `mem_done[w]` for the same warp → READY directly, with no error.
  - Retire of warp A and issue of warp B ≠ A: both take effect.
  - A retiring warp cannot be the issued warp in the same cycle, because it is ISSUED.
  - `start[w]` while retire kind 2 for w: the retire wins, giving DONE; the start is ignored because the state was ISSUED.
  - Multiple `mem_done` bits in one cycle: all are applied.
- Wrap-around: with `last_grant`=NUM_WARPS-1 the scan begins at warp 0.

## Test plan
- **Basic launch and RR.** NUM_WARPS=4, reset, pulse `start`=4'b1111, hold `issue_ready`=1, retire each issue with kind 0 one cycle later → `issue_warp` sequence 0,1,2,3,0,… and no `protocol_err`.
- **Memory parking.** Warps 0 and 1 active. Retire warp 0 with kind 1 → only warp 1 is offered until `mem_done[0]`. Warp 0 is offered again starting the cycle after `mem_done[0]`, in RR order.
- **Fast path and RET.**
  - Retire kind 1 for warp 2 with `mem_done[2]` in the same cycle → `warp_state` w2 = 1 next cycle, no error.
  - Retire kind 2 for every active warp → `done` = launched mask, and `all_done`=1 when the last warp retires.
- **Backpressure.** Hold `issue_ready`=0 for 5 cycles with warps 1 and 3 READY → `issue_warp`=1 stable, `last_grant` unchanged. On release, 1 issues, then 3.
- **Protocol errors.**
  - Retire warp 2 while it is IDLE → `protocol_err`=1, and it stays 1.
  - `mem_done[0]` while READY → no state change.
  - Reset clears the flag.
- **Reset mid-run.** Assert `reset_n`=0 asynchronously while warps are ISSUED/WAIT_MEM → all outputs take reset values immediately. A restart of warp 3 issues warp 3 first.
